// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - EX/MEM consumer: data-memory req/ack access, branch resolve, MEM/WB register
module mem_stage_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       alu_data,
  input  logic [31:0]       branch_target,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              zero,
  input  logic [4:0]        reg_dest,
  input  logic              jump,
  input  logic              branch,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  output logic              pc_src,
  output logic [31:0]       pc_target,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [31:0]       wb_alu_data,
  output logic [4:0]        wb_reg_dest,
  output logic              wb_MemtoReg,
  output logic              wb_RegWrite,
  output logic              misalign_err,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]         lat_alu_q, lat_alu_d;
  logic [4:0]          lat_dest_q, lat_dest_d;
  logic                lat_m2r_q, lat_m2r_d;
  logic                lat_rw_q, lat_rw_d;
  logic                lat_rd_q, lat_rd_d;
  logic [DATA_W-1:0]   wb_rdata_q, wb_rdata_d;
  logic [31:0]         wb_alu_q, wb_alu_d;
  logic [4:0]          wb_dest_q, wb_dest_d;
  logic                wb_m2r_q, wb_m2r_d;
  logic                wb_rw_q, wb_rw_d;
  logic                mis_err_q, mis_err_d;
  logic                to_err_q, to_err_d;
  logic                access;
  logic                misaligned;

  assign access     = MemRead | MemWrite;
  assign misaligned = access & (alu_data[1:0] != 2'b00);

  assign pc_src    = jump | (branch & zero);
  assign pc_target = branch_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lat_alu_q   <= '0;
      lat_dest_q  <= '0;
      lat_m2r_q   <= 1'b0;
      lat_rw_q    <= 1'b0;
      lat_rd_q    <= 1'b0;
      wb_rdata_q  <= '0;
      wb_alu_q    <= '0;
      wb_dest_q   <= '0;
      wb_m2r_q    <= 1'b0;
      wb_rw_q     <= 1'b0;
      mis_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lat_alu_q   <= lat_alu_d;
      lat_dest_q  <= lat_dest_d;
      lat_m2r_q   <= lat_m2r_d;
      lat_rw_q    <= lat_rw_d;
      lat_rd_q    <= lat_rd_d;
      wb_rdata_q  <= wb_rdata_d;
      wb_alu_q    <= wb_alu_d;
      wb_dest_q   <= wb_dest_d;
      wb_m2r_q    <= wb_m2r_d;
      wb_rw_q     <= wb_rw_d;
      mis_err_q   <= mis_err_d;
      to_err_q    <= to_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lat_alu_d   = lat_alu_q;
    lat_dest_d  = lat_dest_q;
    lat_m2r_d   = lat_m2r_q;
    lat_rw_d    = lat_rw_q;
    lat_rd_d    = lat_rd_q;
    wb_rdata_d  = wb_rdata_q;
    wb_alu_d    = wb_alu_q;
    wb_dest_d   = wb_dest_q;
    wb_m2r_d    = wb_m2r_q;
    wb_rw_d     = wb_rw_q;
    mis_err_d   = mis_err_q;
    to_err_d    = to_err_q;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (misaligned) begin
          wb_rw_d   = 1'b0;
          wb_m2r_d  = 1'b0;
          mis_err_d = 1'b1;
        end else if (access) begin
          stall       = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = MemWrite & ~MemRead;
          mem_addr_d  = alu_data[ADDR_W-1:0];
          mem_wdata_d = rt_data;
          lat_alu_d   = alu_data;
          lat_dest_d  = reg_dest;
          lat_m2r_d   = MemtoReg;
          lat_rw_d    = RegWrite;
          lat_rd_d    = MemRead;
          cnt_d       = '0;
          wb_rw_d     = 1'b0;
          wb_m2r_d    = 1'b0;
          state_d     = BUSY;
        end else begin
          wb_alu_d  = alu_data;
          wb_dest_d = reg_dest;
          wb_m2r_d  = MemtoReg;
          wb_rw_d   = RegWrite;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          // Ack beats the timeout even on the last allowed cycle.
          mem_req_d = 1'b0;
          if (lat_rd_q) wb_rdata_d = mem_rdata;
          wb_alu_d  = lat_alu_q;
          wb_dest_d = lat_dest_q;
          wb_m2r_d  = lat_m2r_q;
          wb_rw_d   = lat_rw_q;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          to_err_d  = 1'b1;
          wb_rw_d   = 1'b0;
          wb_m2r_d  = 1'b0;
          state_d   = IDLE;
        end else begin
          stall    = 1'b1;
          wb_rw_d  = 1'b0;
          wb_m2r_d = 1'b0;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_read_data = wb_rdata_q;
  assign wb_alu_data  = wb_alu_q;
  assign wb_reg_dest  = wb_dest_q;
  assign wb_MemtoReg  = wb_m2r_q;
  assign wb_RegWrite  = wb_rw_q;
  assign misalign_err = mis_err_q;
  assign timeout_err  = to_err_q;

endmodule
